// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: shared UART defaults, FSM state encoding and counter sizing
package uart_rx_frame_pkg;
  localparam int DEF_BAUD = 9600;
  localparam int DEF_FREQ = 12000000;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_rx_frame_sync2.sv
// uart_rx_frame_sync2: two-flop synchronizer with a parameterised reset value
module uart_rx_frame_sync2 #(
  parameter logic rst_val = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) {q, m} <= {2{rst_val}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with valid/ready holding register, framing-error and overrun pulses
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int baud = DEF_BAUD,
  parameter int freq = DEF_FREQ
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int lim = freq / baud;
  localparam int half = lim / 2;
  localparam int cw = cnt_w(lim);
  state_t state, state_n;
  logic rx_s;
  logic [cw-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic at_half, at_lim, stop_smp, load;
  uart_rx_frame_sync2 #(.rst_val(1'b1)) u_sync (.clk(clk), .nrst(nrst), .d(rx), .q(rx_s));
  assign at_half = cnt == cw'(half - 1);
  assign at_lim = cnt == cw'(lim - 1);
  assign stop_smp = state == STOP && at_lim;
  // a byte arriving while the old one is being consumed still loads
  assign load = stop_smp && rx_s && (!rx_valid || rx_ready);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   state_n = at_half ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = at_lim && idx == 3'd7 ? STOP : DATA;
      STOP:    state_n = at_lim ? (rx_s ? IDLE : BRK) : STOP;
      BRK:     state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || at_lim) ? '0 : cnt + 1'b1;
      idx <= state == START ? 3'd0 : (state == DATA && at_lim) ? idx + 3'd1 : idx;
      if (state == DATA && at_lim) sh <= {rx_s, sh[7:1]};
      frame_err <= stop_smp && !rx_s;
      overrun <= stop_smp && rx_s && rx_valid && !rx_ready;
      rx_valid <= load || (rx_valid && !rx_ready);
      if (load) rx_data <= sh;
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized frame stimulus checked against a byte-level receiver model
module tb_uart_rx_frame;
  localparam int BAUD = 9600;
  localparam int FREQ = BAUD * 16;
  localparam int LIM = FREQ / BAUD;
  localparam int HALF = LIM / 2;
  localparam int LAT = 3 + HALF - 1 + 9 * LIM + 1;
  logic clk = 1'b0, nrst = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, rise_cyc = -1, data_chg = 0;
  logic busy_seen = 1'b0, prev_v = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] got_q[$], exp_q[$];

  uart_rx_frame #(.baud(BAUD), .freq(FREQ)) dut (
    .clk(clk), .nrst(nrst), .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nrst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_seen = 1'b1;
      if (rx_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
      if (prev_hold && rx_data != prev_data) data_chg++;
      prev_v = rx_valid;
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end else begin
      prev_v = 1'b0;
      prev_hold = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // byte-level view of the receiver: what the consumer should eventually see
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) exp_fe++;
    else if (rx_ready) exp_q.push_back(b);
    else if (m_valid) exp_ov++;
    else begin
      m_valid = 1'b1;
      m_data = b;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    model_frame(b, stop);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      idle(LIM);
    end
  endtask

  task automatic release_ready();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    if (m_valid) exp_q.push_back(m_data);
    m_valid = 1'b0;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, "_frame_err"}, fe_cnt, exp_fe);
    check({tag, "_overrun"}, ov_cnt, exp_ov);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, rx_valid, 1'b0);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    int fall_cyc, lat;
    logic [7:0] a, b;
    idle(5);
    check_reset("rst");
    nrst = 1'b1;
    idle(5);

    fall_cyc = cyc;
    rise_cyc = -1;
    send(8'h53, 1'b1);
    idle(LIM);
    lat = rise_cyc - (fall_cyc + 1);
    check("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
    compare_q("single");

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(LIM);
    compare_q("b2b");

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      rx = 1'b1;
      idle($urandom_range(0, 2 * LIM));
    end
    idle(LIM);
    compare_q("rand");

    busy_seen = 1'b0;
    rx = 1'b0;
    idle(HALF / 2);
    rx = 1'b1;
    idle(2 * LIM);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_end", busy, 1'b0);
    compare_q("glitch");

    send(8'hA5, 1'b0);
    idle(3 * LIM);
    check("break_busy", busy, 1'b1);
    check("break_ferr", fe_cnt, exp_fe);
    rx = 1'b1;
    idle(LIM);
    check("break_exit", busy, 1'b0);
    send(8'h3C, 1'b1);
    idle(LIM);
    compare_q("ferr");

    for (int r = 0; r < 2; r++) begin
      a = r == 0 ? 8'h11 : 8'($urandom_range(0, 255));
      b = r == 0 ? 8'h22 : 8'($urandom_range(0, 255));
      rx_ready = 1'b0;
      send(a, 1'b1);
      send(b, 1'b1);
      idle(LIM);
      check($sformatf("ovr%0d_valid", r), rx_valid, m_valid);
      check($sformatf("ovr%0d_data", r), rx_data, m_data);
      check($sformatf("ovr%0d_count", r), ov_cnt, exp_ov);
      check($sformatf("ovr%0d_stable", r), data_chg, 0);
      release_ready();
      idle(4);
      compare_q($sformatf("ovr%0d", r));
    end

    a = 8'($urandom_range(0, 255));
    rx = 1'b0;
    idle(LIM);
    for (int i = 0; i < 5; i++) begin
      rx = a[i];
      idle(i == 4 ? HALF : LIM);
    end
    nrst = 1'b0;
    rx = 1'b1;
    idle(2);
    check_reset("midrst");
    nrst = 1'b1;
    idle(12 * LIM);
    check("midrst_nobyte", got_q.size(), 0);
    send(8'h7E, 1'b1);
    idle(LIM);
    compare_q("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
